tmds_dc_balance: RTL and testbench

Second stage of the per-channel TMDS encoder in the HDMI output path. Consumes the 9-bit transition-minimized word from the upstream XOR/XNOR choice stage, plus video-enable and control bits from the video timing generator. Produces the final DC-balanced 10-bit TMDS symbol for the serializer. Keeps a running disparity tally so the serial line stays DC-balanced, and emits the four DVI control tokens during blanking.

---
 rtl/tmds_dc_balance_if.sv | 32 +++
 rtl/tmds_dc_balance.sv | 109 ++++++++++
 tb/tb_tmds_dc_balance.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_dc_balance_if.sv
// Per-channel TMDS DC-balance stage bus.
//   ve_in     : video enable (1 = active pixel, 0 = blanking)
//   ctrl_in   : {C1,C0} control bits, meaningful only while ve_in = 0
//   qm_in     : 9-bit transition-minimized word, bit 8 = 1 means XOR encoding
//   tmds_out  : registered 10-bit TMDS symbol
//   tally_out : registered signed running disparity
// master drives the pixel side and observes the symbol; slave is the encoder.
interface tmds_dc_balance_if #(
  parameter int unsigned TALLY_W = 5
);
  logic                      ve_in;
  logic [1:0]                ctrl_in;
  logic [8:0]                qm_in;
  logic [9:0]                tmds_out;
  logic signed [TALLY_W-1:0] tally_out;

  modport master (
    output ve_in,
    output ctrl_in,
    output qm_in,
    input  tmds_out,
    input  tally_out
  );

  modport slave (
    input  ve_in,
    input  ctrl_in,
    input  qm_in,
    output tmds_out,
    output tally_out
  );
endinterface

// File: rtl/tmds_dc_balance.sv
// TMDS DC-balance stage: turns the 9-bit transition-minimized word into the final
// 10-bit symbol, tracking a signed running disparity; emits DVI control tokens in
// blanking. Two register stages, one symbol per clock, no handshake.
//   clk_in : pixel clock
//   rst_in : asynchronous active-high reset
//   bus    : tmds_dc_balance_if slave (ve_in, ctrl_in, qm_in in; tmds_out, tally_out out)
module tmds_dc_balance #(
  parameter int unsigned TALLY_W = 5
) (
  input logic              clk_in,
  input logic              rst_in,
  tmds_dc_balance_if.slave bus
);

  localparam logic [9:0] CtrlTok00 = 10'b1101010100;
  localparam logic [9:0] CtrlTok01 = 10'b0010101011;
  localparam logic [9:0] CtrlTok10 = 10'b0101010100;
  localparam logic [9:0] CtrlTok11 = 10'b1010101011;

  localparam logic signed [TALLY_W-1:0] Eight = TALLY_W'(8);
  localparam logic signed [TALLY_W-1:0] Two   = TALLY_W'(2);
  localparam logic signed [TALLY_W-1:0] Zero  = '0;

  // Stage 1
  logic       ve_q;
  logic [1:0] ctrl_q;
  logic [8:0] qm_q;
  logic [3:0] n1_d, n1_q;

  // Stage 2
  logic [9:0]                tmds_d, tmds_q;
  logic signed [TALLY_W-1:0] tally_d, tally_q;

  always_comb begin
    n1_d = '0;
    for (int i = 0; i < 8; i++) begin
      n1_d = n1_d + 4'(bus.qm_in[i]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ve_q   <= 1'b0;
      ctrl_q <= 2'b00;
      qm_q   <= '0;
      n1_q   <= '0;
    end else begin
      ve_q   <= bus.ve_in;
      ctrl_q <= bus.ctrl_in;
      qm_q   <= bus.qm_in;
      n1_q   <= n1_d;
    end
  end

  logic signed [TALLY_W-1:0] n1_w;
  logic signed [TALLY_W-1:0] diff_w;   // n1 - n0 = 2*n1 - 8
  logic                      tally_zero;
  logic                      tally_neg;
  logic                      balanced;
  logic                      excess_ones;
  logic                      excess_zeros;

  always_comb begin
    n1_w         = TALLY_W'(n1_q);
    diff_w       = n1_w + n1_w - Eight;
    tally_zero   = (tally_q == Zero);
    tally_neg    = tally_q[TALLY_W-1];
    balanced     = (n1_q == 4'd4);
    excess_ones  = (n1_q > 4'd4);
    excess_zeros = (n1_q < 4'd4);

    tmds_d  = CtrlTok00;
    tally_d = Zero;

    if (!ve_q) begin
      unique case (ctrl_q)
        2'b00: tmds_d = CtrlTok00;
        2'b01: tmds_d = CtrlTok01;
        2'b10: tmds_d = CtrlTok10;
        2'b11: tmds_d = CtrlTok11;
      endcase
      tally_d = Zero;
    end else if (tally_zero || balanced) begin
      tmds_d  = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      tally_d = qm_q[8] ? (tally_q + diff_w) : (tally_q - diff_w);
    end else if ((!tally_neg && excess_ones) || (tally_neg && excess_zeros)) begin
      // Disparity would grow: invert data bits to pull the tally back toward zero.
      tmds_d  = {1'b1, qm_q[8], ~qm_q[7:0]};
      tally_d = tally_q - diff_w + (qm_q[8] ? Two : Zero);
    end else begin
      tmds_d  = {1'b0, qm_q[8], qm_q[7:0]};
      tally_d = tally_q + diff_w - (qm_q[8] ? Zero : Two);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tmds_q  <= CtrlTok00;
      tally_q <= Zero;
    end else begin
      tmds_q  <= tmds_d;
      tally_q <= tally_d;
    end
  end

  assign bus.tmds_out  = tmds_q;
  assign bus.tally_out = tally_q;

endmodule

// File: tb/tb_tmds_dc_balance.sv
module tb_tmds_dc_balance;
  localparam int unsigned TW = 5;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  tmds_dc_balance_if #(.TALLY_W(TW)) bus ();

  tmds_dc_balance #(.TALLY_W(TW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: integer disparity and a queue of expected outputs.
  int         m_tally;
  logic [9:0] q_tmds[$];
  int         q_tally[$];

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  task automatic model_push(input logic ve, input logic [1:0] ctrl, input logic [8:0] qm);
    int n1, n0, q8;
    logic [9:0] t;
    logic [7:0] d;
    d  = qm[7:0];
    n1 = $countones(d);
    n0 = 8 - n1;
    q8 = qm[8] ? 1 : 0;
    if (!ve) begin
      t = token(ctrl);
      m_tally = 0;
    end else if (m_tally == 0 || n1 == n0) begin
      t = qm[8] ? {2'b01, d} : {2'b10, ~d};
      m_tally = m_tally + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((m_tally > 0 && n1 > n0) || (m_tally < 0 && n0 > n1)) begin
      t = {1'b1, qm[8], ~d};
      m_tally = m_tally + 2 * q8 + (n0 - n1);
    end else begin
      t = {1'b0, qm[8], d};
      m_tally = m_tally + (n1 - n0) - 2 * (1 - q8);
    end
    q_tmds.push_back(t);
    q_tally.push_back(m_tally);
  endtask

  task automatic model_reset();
    m_tally = 0;
    q_tmds.delete();
    q_tally.delete();
    // Stage 1 holds blanking/ctrl 00 out of reset.
    q_tmds.push_back(10'h354);
    q_tally.push_back(0);
  endtask

  // Apply one input, clock once, return the observed output and the model's
  // expectation for the same symbol (the input applied one call earlier).
  task automatic cycle(input logic ve, input logic [1:0] ctrl, input logic [8:0] qm,
                       output logic [9:0] obs_t, output int obs_tal,
                       output logic [9:0] exp_t, output int exp_tal);
    bus.ve_in   = ve;
    bus.ctrl_in = ctrl;
    bus.qm_in   = qm;
    model_push(ve, ctrl, qm);
    @(posedge clk_in);
    #1;
    obs_t   = bus.tmds_out;
    obs_tal = int'(bus.tally_out);
    exp_t   = q_tmds.pop_front();
    exp_tal = q_tally.pop_front();
  endtask

  task automatic test_reset();
    logic [9:0] ot, et;
    int ol, el;
    rst_in      = 1'b1;
    bus.ve_in   = 1'b1;
    bus.ctrl_in = 2'b11;
    bus.qm_in   = 9'h1FF;
    repeat (2) @(posedge clk_in);
    #3;
    total++;
    if (bus.tmds_out !== 10'h354) begin
      bad++;
      $display("FAIL reset_tmds: got %h want 354", bus.tmds_out);
    end
    total++;
    if (bus.tally_out !== '0) begin
      bad++;
      $display("FAIL reset_tally: got %0d want 0", bus.tally_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    // First edge after release still shows the reset contents of stage 1.
    cycle(1'b1, 2'b00, 9'h1FF, ot, ol, et, el);
    total++;
    if (ot !== 10'h354 || ol != 0) begin
      bad++;
      $display("FAIL reset_release_hold: got %h/%0d want 354/0", ot, ol);
    end
    cycle(1'b0, 2'b00, 9'h000, ot, ol, et, el);
    total++;
    if (ot !== 10'h1FF || ol != 8) begin
      bad++;
      $display("FAIL reset_first_active: got %h/%0d want 1ff/8", ot, ol);
    end
  endtask

  task automatic test_ctrl_tokens();
    logic [9:0] ot, et;
    int ol, el;
    logic [9:0] want[4];
    want = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 2'(i), 9'(i * 37), ot, ol, et, el);
      if (i > 0) begin
        total++;
        if (ot !== want[i-1] || ol != 0) begin
          bad++;
          $display("FAIL ctrl_token_%0d: got %h/%0d want %h/0", i - 1, ot, ol, want[i-1]);
        end
      end
    end
  endtask

  task automatic test_cases_abc();
    logic [9:0] ot, et;
    int ol, el;
    logic       ve_v[8];
    logic [1:0] ctrl_v[8];
    logic [8:0] qm_v[8];
    logic [9:0] want_t[7];
    int         want_l[7];
    ve_v   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    ctrl_v = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    qm_v   = '{9'h100, 9'h100, 9'h000, 9'h10F, 9'h00F, 9'h0AA, 9'h1FF, 9'h000};
    want_t = '{10'h100, 10'h3FF, 10'h000, 10'h10F, 10'h2F0, 10'h154, 10'h1FF};
    want_l = '{-8, 2, -8, -8, -8, 0, 8};
    for (int i = 0; i < 8; i++) begin
      cycle(ve_v[i], ctrl_v[i], qm_v[i], ot, ol, et, el);
      if (i > 0) begin
        total++;
        if (ot !== want_t[i-1] || ol != want_l[i-1]) begin
          bad++;
          $display("FAIL case_step_%0d: got %h/%0d want %h/%0d",
                   i - 1, ot, ol, want_t[i-1], want_l[i-1]);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [9:0] ot, et;
    int ol, el;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 2'b00, 9'($urandom), ot, ol, et, el);
    end
    cycle(1'b1, 2'b00, 9'h100, ot, ol, et, el);
    #2;
    rst_in = 1'b1;
    #1;
    total++;
    if (bus.tmds_out !== 10'h354 || bus.tally_out !== '0) begin
      bad++;
      $display("FAIL midreset_async: got %h/%0d want 354/0", bus.tmds_out, bus.tally_out);
    end
    @(posedge clk_in);
    #1;
    total++;
    if (bus.tmds_out !== 10'h354 || bus.tally_out !== '0) begin
      bad++;
      $display("FAIL midreset_held: got %h/%0d want 354/0", bus.tmds_out, bus.tally_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    cycle(1'b1, 2'b00, 9'h0FF, ot, ol, et, el);
    total++;
    if (ot !== 10'h354 || ol != 0) begin
      bad++;
      $display("FAIL midreset_flush: got %h/%0d want 354/0", ot, ol);
    end
  endtask

  task automatic test_random();
    logic [9:0] ot, et;
    int ol, el;
    logic ve;
    for (int i = 0; i < 800; i++) begin
      ve = ($urandom_range(0, 15) != 0);
      cycle(ve, 2'($urandom), 9'($urandom), ot, ol, et, el);
      total++;
      if (ot !== et) begin
        bad++;
        $display("FAIL rand_tmds[%0d]: got %h want %h", i, ot, et);
      end
      total++;
      if (ol != el) begin
        bad++;
        $display("FAIL rand_tally[%0d]: got %0d want %0d", i, ol, el);
      end
      total++;
      if (ol > 10 || ol < -10) begin
        bad++;
        $display("FAIL rand_tally_bound[%0d]: got %0d want within -10..10", i, ol);
      end
    end
  endtask

  initial begin
    bus.ve_in   = 1'b0;
    bus.ctrl_in = 2'b00;
    bus.qm_in   = '0;
    test_reset();
    test_ctrl_tokens();
    test_cases_abc();
    test_midstream_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
